// File: rtl/ft_recovery_unit.sv
// Lockstep recovery: golden shadow RF + PC, replayed into both cores on error.
// All outputs are registered from the next-state logic.
module ft_recovery_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  error_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pc_valid_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  halt_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic                  pc_restore_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  busy_o,
  output logic [7:0]            recovery_count_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    HALT,
    RESTORE,
    PCRST
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shadow_q [DEPTH];
  logic [DATA_WIDTH-1:0] gpc_q;

  logic                  capture;
  logic                  rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_data_d;
  logic                  pc_restore_d;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [7:0]            count_d;

  assign capture = (state_q == IDLE) && !error_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = '0;
    pc_restore_d = 1'b0;
    pc_d         = '0;
    count_d      = recovery_count_o;
    unique case (state_q)
      IDLE: begin
        if (error_i) state_d = HALT;
      end
      HALT: begin
        state_d   = RESTORE;
        cnt_d     = ADDR_WIDTH'(1);
        rf_we_d   = 1'b1;
        rf_addr_d = ADDR_WIDTH'(1);
      end
      RESTORE: begin
        // cnt_q is the address on the outputs this cycle
        if (cnt_q == LAST) begin
          state_d      = PCRST;
          pc_restore_d = 1'b1;
          pc_d         = gpc_q;
          if (recovery_count_o != 8'hFF)
            count_d = recovery_count_o + 8'd1;
        end else begin
          cnt_d     = cnt_q + ADDR_WIDTH'(1);
          rf_we_d   = 1'b1;
          rf_addr_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      PCRST: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    rf_data_d = rf_we_d ? shadow_q[rf_addr_d] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      halt_o           <= 1'b0;
      busy_o           <= 1'b0;
      rf_we_o          <= 1'b0;
      rf_addr_o        <= '0;
      rf_data_o        <= '0;
      pc_restore_o     <= 1'b0;
      pc_o             <= '0;
      recovery_count_o <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      halt_o           <= (state_d != IDLE);
      busy_o           <= (state_d != IDLE);
      rf_we_o          <= rf_we_d;
      rf_addr_o        <= rf_addr_d;
      rf_data_o        <= rf_data_d;
      pc_restore_o     <= pc_restore_d;
      pc_o             <= pc_d;
      recovery_count_o <= count_d;
    end
  end

  // Entry 0 is never written, so it stays at its reset value of 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
      gpc_q <= '0;
    end else begin
      if (capture && we_i && addr_i != '0)
        shadow_q[addr_i] <= data_i;
      if (capture && pc_valid_i)
        gpc_q <= pc_i;
    end
  end

endmodule

// File: tb/tb_ft_recovery_unit.sv
// Scoreboard bench for ft_recovery_unit: stimulus queues expected restore
// writes and PC pulses, a negedge monitor pops and compares them.
module tb_ft_recovery_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        error_i = 1'b0;
  logic        we_i = 1'b0;
  logic [4:0]  addr_i = '0;
  logic [31:0] data_i = '0;
  logic        pc_valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        halt_o;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        pc_restore_o;
  logic [31:0] pc_o;
  logic        busy_o;
  logic [7:0]  recovery_count_o;

  typedef struct {
    logic        is_pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_sh [32];
  logic [31:0] exp_pc;
  int          exp_count;
  int          tests = 0;
  int          fails = 0;

  ft_recovery_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .error_i(error_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .pc_valid_i(pc_valid_i), .pc_i(pc_i),
    .halt_o(halt_o), .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o),
    .rf_data_o(rf_data_o), .pc_restore_o(pc_restore_o), .pc_o(pc_o),
    .busy_o(busy_o), .recovery_count_o(recovery_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && (rf_we_o || pc_restore_o)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: we=%0b addr=%0d pc_restore=%0b",
                 rf_we_o, rf_addr_o, pc_restore_o);
      end else begin
        e = sb.pop_front();
        if (e.is_pc) begin
          chk("pc_kind", {rf_we_o, pc_restore_o}, 2'b01);
          chk("pc_value", pc_o, e.data);
        end else begin
          chk("rf_kind", {rf_we_o, pc_restore_o}, 2'b10);
          chk($sformatf("rf_addr_%0d", e.addr), rf_addr_o, e.addr);
          chk($sformatf("rf_data_%0d", e.addr), rf_data_o, e.data);
        end
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; data_i = d;
    @(posedge clk_i); #1;
    we_i = 1'b0; addr_i = '0; data_i = '0;
  endtask

  task automatic pcw(input logic [31:0] p);
    pc_valid_i = 1'b1; pc_i = p;
    @(posedge clk_i); #1;
    pc_valid_i = 1'b0; pc_i = '0;
  endtask

  task automatic clear_in();
    we_i = 1'b0; addr_i = '0; data_i = '0;
    pc_valid_i = 1'b0; pc_i = '0; error_i = 1'b0;
  endtask

  task automatic push_expect();
    for (int a = 1; a < 32; a++)
      sb.push_back('{1'b0, 5'(a), exp_sh[a]});
    sb.push_back('{1'b1, 5'd0, exp_pc});
    if (exp_count < 255) exp_count++;
  endtask

  // Error cycle optionally carries a write/PC strobe; noise pokes inputs
  // while the recovery is running.
  task automatic recover(input logic w, input logic [4:0] a,
                         input logic [31:0] d, input bit noise);
    int n;
    push_expect();
    we_i = w; addr_i = a; data_i = d;
    pc_valid_i = w; pc_i = 32'h200; error_i = 1'b1;
    @(posedge clk_i); #1;
    clear_in();
    chk("halt_rise", {halt_o, busy_o}, 2'b11);
    n = 0;
    while (halt_o && n < 100) begin
      if (noise && n >= 3 && n <= 8) begin
        we_i = 1'b1; addr_i = 5'd7; data_i = 32'h55;
        pc_valid_i = 1'b1; pc_i = 32'h999; error_i = n[0];
      end else begin
        clear_in();
      end
      @(posedge clk_i); #1;
      n++;
    end
    clear_in();
    chk("halt_cycles", n, 33);
    chk("recovery_count", recovery_count_o, exp_count);
    repeat (3) @(posedge clk_i);
    #1;
    chk("idle_after", {halt_o, busy_o, rf_we_o, pc_restore_o}, 4'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) exp_sh[i] = '0;
    exp_pc = '0;
    exp_count = 0;

    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_ctrl", {halt_o, busy_o, rf_we_o, pc_restore_o}, 4'b0);
    chk("reset_rf", {rf_addr_o, rf_data_o}, 37'h0);
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_count", recovery_count_o, 8'h0);

    wr(5'd3, 32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    pcw(32'h100);
    exp_sh[3] = 32'hDEADBEEF;
    exp_sh[31] = 32'h12345678;
    exp_pc = 32'h100;
    recover(1'b0, 5'd0, 32'h0, 1'b0);

    recover(1'b1, 5'd5, 32'hAAAA, 1'b0);

    wr(5'd0, 32'hFFFFFFFF);
    recover(1'b0, 5'd0, 32'h0, 1'b0);

    recover(1'b0, 5'd0, 32'h0, 1'b1);

    push_expect();
    error_i = 1'b1;
    @(posedge clk_i); #1;
    error_i = 1'b0;
    n = 0;
    while (!(rf_we_o && rf_addr_o == 5'd10) && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("reach_addr10", n < 50, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_ctrl", {halt_o, busy_o, rf_we_o, pc_restore_o}, 4'b0);
    chk("async_rst_data", {rf_addr_o, rf_data_o, pc_o}, 69'h0);
    chk("async_rst_count", recovery_count_o, 8'h0);
    sb.delete();
    for (int i = 0; i < 32; i++) exp_sh[i] = '0;
    exp_pc = '0;
    exp_count = 0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    recover(1'b0, 5'd0, 32'h0, 1'b0);

    for (int k = 0; k < 256; k++) begin
      push_expect();
      error_i = 1'b1;
      @(posedge clk_i); #1;
      error_i = 1'b0;
      n = 0;
      while (halt_o && n < 100) begin
        @(posedge clk_i); #1;
        n++;
      end
      if (n >= 100) chk("sat_timeout", n, 33);
    end
    chk("count_saturated", recovery_count_o, 8'd255);

    repeat (2) @(posedge clk_i);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
